// File: rtl/map_latch_gen.sv
// Discrete latch mapper: CPU-written PRG/CHR bank and mirroring latches, optional M2 IRQ down-counter.
// Build macro MAP_LATCH_IRQ_EN adds the counter (split layout only); all state changes on the m2 falling edge.
module map_latch_gen #(
    parameter int unsigned PRG_BITS  = 3,
    parameter int unsigned CHR_BITS  = 4,
    parameter logic [15:0] REG_MASK  = 16'hE100,
    parameter logic [15:0] REG_MATCH = 16'h4100,
    parameter int unsigned LAYOUT    = 0,
    parameter int unsigned MIR_CTL   = 0
) (
    input  logic                       m2,
    input  logic                       map_rst_n,
    input  logic [15:0]                cpu_addr,
    input  logic [7:0]                 cpu_data,
    input  logic                       cpu_rw,
    input  logic [13:0]                ppu_addr,
    input  logic                       ppu_oe_n,
    input  logic                       ppu_we_n,
    input  logic                       cfg_mir_v,
    input  logic                       cfg_chr_ram,
    input  logic [7:0]                 cfg_map_idx,
    input  logic                       sst_act,
    input  logic                       sst_we_reg,
    input  logic [7:0]                 sst_addr,
    input  logic [7:0]                 sst_dato,
    output logic [7:0]                 sst_di,
    output logic                       prg_ce,
    output logic                       prg_oe,
    output logic [15+PRG_BITS-1:0]     prg_addr,
    output logic                       chr_ce,
    output logic                       chr_oe,
    output logic                       chr_we,
    output logic [13+CHR_BITS-1:0]     chr_addr,
    output logic                       ciram_ce,
    output logic                       ciram_a10,
    output logic                       irq
);

    typedef enum logic [7:0] {
        SST_PRG    = 8'd0,
        SST_CHR    = 8'd1,
        SST_MIR    = 8'd2,
        SST_CNT_LO = 8'd3,
        SST_CNT_HI = 8'd4,
        SST_IRQ    = 8'd5,
        SST_MAP    = 8'd127
    } sst_idx_e;

    localparam bit SPLIT = (LAYOUT != 0);

    logic                w_wr;
    logic                w_mir_sel;
    logic [PRG_BITS-1:0] r_prg;
    logic [CHR_BITS-1:0] r_chr;
    logic                r_mir;

    assign w_wr = !cpu_rw && ((cpu_addr & REG_MASK) == REG_MATCH);

    always_ff @(negedge m2) begin
        if (sst_act) begin
            if (sst_we_reg) begin
                case (sst_addr)
                    SST_PRG: r_prg <= PRG_BITS'(sst_dato);
                    SST_CHR: r_chr <= CHR_BITS'(sst_dato);
                    SST_MIR: r_mir <= sst_dato[0];
                    default: ;
                endcase
            end
        end else if (!map_rst_n) begin
            r_prg <= '0;
            r_chr <= '0;
            r_mir <= 1'b0;
        end else if (w_wr) begin
            if (!SPLIT) begin
                r_prg <= PRG_BITS'(cpu_data[5:3]);
                r_chr <= CHR_BITS'({cpu_data[6], cpu_data[2:0]});
                r_mir <= cpu_data[7];
            end else if (cpu_addr[1:0] == 2'b00) begin
                r_prg <= PRG_BITS'(cpu_data);
                r_mir <= cpu_data[7];
            end else if (cpu_addr[1:0] == 2'b01) begin
                r_chr <= CHR_BITS'(cpu_data);
            end
        end
    end

`ifdef MAP_LATCH_IRQ_EN
    localparam bit HAS_IRQ = SPLIT;

    logic [15:0] r_cnt;
    logic        r_irq_en;
    logic        r_irq_pend;
    logic        w_cnt_wr;
    logic        w_cnt_zero;

    assign w_cnt_wr   = HAS_IRQ && w_wr && cpu_addr[1];
    assign w_cnt_zero = (r_cnt == 16'd0);

    // A counter write replaces that edge's tick; a low-byte write on the
    // expiring edge also disarms, so the IRQ it would have raised never fires.
    always_ff @(negedge m2) begin
        if (!HAS_IRQ) begin
            r_cnt      <= '0;
            r_irq_en   <= 1'b0;
            r_irq_pend <= 1'b0;
        end else if (sst_act) begin
            if (sst_we_reg) begin
                case (sst_addr)
                    SST_CNT_LO: r_cnt[7:0]  <= sst_dato;
                    SST_CNT_HI: r_cnt[15:8] <= sst_dato;
                    SST_IRQ: begin
                        r_irq_en   <= sst_dato[1];
                        r_irq_pend <= sst_dato[0];
                    end
                    default: ;
                endcase
            end
        end else if (!map_rst_n) begin
            r_cnt      <= '0;
            r_irq_en   <= 1'b0;
            r_irq_pend <= 1'b0;
        end else if (w_cnt_wr) begin
            if (!cpu_addr[0]) begin
                r_cnt[7:0] <= cpu_data;
                r_irq_pend <= 1'b0;
                if (r_irq_en && w_cnt_zero) r_irq_en <= 1'b0;
            end else begin
                r_cnt[15:8] <= cpu_data;
                r_irq_en    <= cpu_data[7];
            end
        end else if (r_irq_en) begin
            if (w_cnt_zero) begin
                r_irq_pend <= 1'b1;
                r_irq_en   <= 1'b0;
            end else begin
                r_cnt <= r_cnt - 16'd1;
            end
        end
    end

    assign irq = r_irq_pend;
`else
    assign irq = 1'b0;
`endif

    always_comb begin
        sst_di = 8'hFF;
        case (sst_addr)
            SST_PRG: sst_di = 8'(r_prg);
            SST_CHR: sst_di = 8'(r_chr);
            SST_MIR: sst_di = {7'b0, r_mir};
`ifdef MAP_LATCH_IRQ_EN
            SST_CNT_LO: if (HAS_IRQ) sst_di = r_cnt[7:0];
            SST_CNT_HI: if (HAS_IRQ) sst_di = r_cnt[15:8];
            SST_IRQ:    if (HAS_IRQ) sst_di = {6'b0, r_irq_en, r_irq_pend};
`endif
            SST_MAP: sst_di = cfg_map_idx;
            default: sst_di = 8'hFF;
        endcase
    end

    assign w_mir_sel = (MIR_CTL != 0) ? r_mir : cfg_mir_v;

    assign prg_ce    = cpu_addr[15];
    assign prg_oe    = cpu_rw;
    assign prg_addr  = {r_prg, cpu_addr[14:0]};
    assign chr_ce    = !ppu_addr[13];
    assign chr_oe    = !ppu_oe_n;
    assign chr_we    = cfg_chr_ram && !ppu_we_n && !ppu_addr[13];
    assign chr_addr  = {r_chr, ppu_addr[12:0]};
    assign ciram_ce  = !ppu_addr[13];
    assign ciram_a10 = w_mir_sel ? ppu_addr[10] : ppu_addr[11];

endmodule

// File: tb/tb_map_latch_gen.sv
// Scoreboard bench for map_latch_gen: packed-layout instance and split-layout/MIR_CTL=1 instance on a shared bus.
module tb_map_latch_gen;

`ifdef MAP_LATCH_IRQ_EN
    localparam bit IRQ_BUILT = 1'b1;
`else
    localparam bit IRQ_BUILT = 1'b0;
`endif

    logic        m2 = 1'b1;
    logic        map_rst_n = 1'b0;
    logic [15:0] cpu_addr = 16'h0000;
    logic [7:0]  cpu_data = 8'h00;
    logic        cpu_rw = 1'b1;
    logic [13:0] ppu_addr = 14'h0000;
    logic        ppu_oe_n = 1'b1;
    logic        ppu_we_n = 1'b1;
    logic        cfg_mir_v = 1'b0;
    logic        cfg_chr_ram = 1'b0;
    logic [7:0]  cfg_map_idx = 8'h4E;
    logic        sst_act = 1'b0;
    logic        sst_we_reg = 1'b0;
    logic [7:0]  sst_addr = 8'h00;
    logic [7:0]  sst_dato = 8'h00;

    logic [7:0]  o0_sst_di, o1_sst_di;
    logic        o0_prg_ce, o0_prg_oe, o0_chr_ce, o0_chr_oe, o0_chr_we, o0_ciram_ce, o0_ciram_a10, o0_irq;
    logic        o1_prg_ce, o1_prg_oe, o1_chr_ce, o1_chr_oe, o1_chr_we, o1_ciram_ce, o1_ciram_a10, o1_irq;
    logic [17:0] o0_prg_addr;
    logic [16:0] o0_chr_addr;
    logic [19:0] o1_prg_addr;
    logic [16:0] o1_chr_addr;

    always #5 m2 = ~m2;

    map_latch_gen u0 (
        .m2(m2), .map_rst_n(map_rst_n), .cpu_addr(cpu_addr), .cpu_data(cpu_data), .cpu_rw(cpu_rw),
        .ppu_addr(ppu_addr), .ppu_oe_n(ppu_oe_n), .ppu_we_n(ppu_we_n), .cfg_mir_v(cfg_mir_v),
        .cfg_chr_ram(cfg_chr_ram), .cfg_map_idx(cfg_map_idx), .sst_act(sst_act), .sst_we_reg(sst_we_reg),
        .sst_addr(sst_addr), .sst_dato(sst_dato), .sst_di(o0_sst_di), .prg_ce(o0_prg_ce), .prg_oe(o0_prg_oe),
        .prg_addr(o0_prg_addr), .chr_ce(o0_chr_ce), .chr_oe(o0_chr_oe), .chr_we(o0_chr_we),
        .chr_addr(o0_chr_addr), .ciram_ce(o0_ciram_ce), .ciram_a10(o0_ciram_a10), .irq(o0_irq)
    );

    map_latch_gen #(.PRG_BITS(5), .CHR_BITS(4), .LAYOUT(1), .MIR_CTL(1)) u1 (
        .m2(m2), .map_rst_n(map_rst_n), .cpu_addr(cpu_addr), .cpu_data(cpu_data), .cpu_rw(cpu_rw),
        .ppu_addr(ppu_addr), .ppu_oe_n(ppu_oe_n), .ppu_we_n(ppu_we_n), .cfg_mir_v(cfg_mir_v),
        .cfg_chr_ram(cfg_chr_ram), .cfg_map_idx(cfg_map_idx), .sst_act(sst_act), .sst_we_reg(sst_we_reg),
        .sst_addr(sst_addr), .sst_dato(sst_dato), .sst_di(o1_sst_di), .prg_ce(o1_prg_ce), .prg_oe(o1_prg_oe),
        .prg_addr(o1_prg_addr), .chr_ce(o1_chr_ce), .chr_oe(o1_chr_oe), .chr_we(o1_chr_we),
        .chr_addr(o1_chr_addr), .ciram_ce(o1_ciram_ce), .ciram_a10(o1_ciram_a10), .irq(o1_irq)
    );

    typedef struct {
        int prg;
        int chr;
        int mir;
        int cnt;
        int en;
        int pend;
    } st_t;

    typedef struct {
        int prg0, chr0, cir0, sst0, irq0, strb;
        int prg1, chr1, cir1, sst1, irq1;
    } exp_t;

    st_t  s0, s1;
    exp_t q[$];
    exp_t mon_e;
    int   checks = 0;
    int   failures = 0;

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
        end
    endfunction

    function automatic st_t zero_st();
        st_t z;
        z.prg = 0; z.chr = 0; z.mir = 0; z.cnt = 0; z.en = 0; z.pend = 0;
        return z;
    endfunction

    // Next-state of one mapper instance from the currently applied bus values.
    function automatic st_t step(input st_t s, input bit split, input int pb, input int cb, input bit hirq);
        st_t n;
        int  d;
        int  sd;
        bit  wr;
        bit  cntwr;
        n = s;
        d = int'(cpu_data);
        sd = int'(sst_dato);
        wr = !cpu_rw && ((cpu_addr & 16'hE100) == 16'h4100);
        cntwr = 1'b0;
        if (sst_act) begin
            if (sst_we_reg) begin
                case (int'(sst_addr))
                    0: n.prg = sd % (1 << pb);
                    1: n.chr = sd % (1 << cb);
                    2: n.mir = sd % 2;
                    3: if (hirq) n.cnt = (s.cnt / 256) * 256 + sd;
                    4: if (hirq) n.cnt = sd * 256 + s.cnt % 256;
                    5: if (hirq) begin n.en = (sd / 2) % 2; n.pend = sd % 2; end
                    default: ;
                endcase
            end
        end else if (!map_rst_n) begin
            n = zero_st();
        end else begin
            if (wr && !split) begin
                n.prg = ((d / 8) % 8) % (1 << pb);
                n.chr = (((d / 64) % 2) * 8 + d % 8) % (1 << cb);
                n.mir = d / 128;
            end else if (wr) begin
                case (int'(cpu_addr % 4))
                    0: begin n.prg = d % (1 << pb); n.mir = d / 128; end
                    1: n.chr = d % (1 << cb);
                    2: if (hirq) begin
                        cntwr = 1'b1;
                        n.cnt = (s.cnt / 256) * 256 + d;
                        n.pend = 0;
                        if (s.en == 1 && s.cnt == 0) n.en = 0;
                    end
                    default: if (hirq) begin
                        cntwr = 1'b1;
                        n.cnt = d * 256 + s.cnt % 256;
                        n.en = d / 128;
                    end
                endcase
            end
            if (hirq && s.en == 1 && !cntwr) begin
                if (s.cnt == 0) begin n.pend = 1; n.en = 0; end
                else n.cnt = s.cnt - 1;
            end
        end
        return n;
    endfunction

    function automatic int sst_read(input st_t s, input bit hirq);
        case (int'(sst_addr))
            0: return s.prg;
            1: return s.chr;
            2: return s.mir;
            3: return hirq ? s.cnt % 256 : 255;
            4: return hirq ? s.cnt / 256 : 255;
            5: return hirq ? s.en * 2 + s.pend : 255;
            127: return int'(cfg_map_idx);
            default: return 255;
        endcase
    endfunction

    function automatic exp_t expect_now();
        exp_t e;
        int a10, a11, nce;
        a10 = int'(ppu_addr[10]);
        a11 = int'(ppu_addr[11]);
        nce = ppu_addr[13] ? 0 : 1;
        e.prg0 = s0.prg * 32768 + int'(cpu_addr % 32768);
        e.chr0 = s0.chr * 8192 + int'(ppu_addr % 8192);
        e.cir0 = cfg_mir_v ? a10 : a11;
        e.sst0 = sst_read(s0, 1'b0);
        e.irq0 = 0;
        e.strb = int'(cpu_addr[15]) * 32 + int'(cpu_rw) * 16 + nce * 8 + (ppu_oe_n ? 0 : 4)
               + ((cfg_chr_ram && !ppu_we_n && nce == 1) ? 2 : 0) + nce;
        e.prg1 = s1.prg * 32768 + int'(cpu_addr % 32768);
        e.chr1 = s1.chr * 8192 + int'(ppu_addr % 8192);
        e.cir1 = (s1.mir == 1) ? a10 : a11;
        e.sst1 = sst_read(s1, IRQ_BUILT);
        e.irq1 = s1.pend;
        return e;
    endfunction

    // Monitor: compares everything the DUT presents half a cycle after each update edge.
    always @(posedge m2) begin
        if (q.size() > 0) begin
            mon_e = q.pop_front();
            chk("u0_prg_addr", 32'(o0_prg_addr), mon_e.prg0);
            chk("u0_chr_addr", 32'(o0_chr_addr), mon_e.chr0);
            chk("u0_ciram_a10", 32'(o0_ciram_a10), mon_e.cir0);
            chk("u0_sst_di", 32'(o0_sst_di), mon_e.sst0);
            chk("u0_irq", 32'(o0_irq), mon_e.irq0);
            chk("u0_strobes", 32'({o0_prg_ce, o0_prg_oe, o0_chr_ce, o0_chr_oe, o0_chr_we, o0_ciram_ce}), mon_e.strb);
            chk("u1_prg_addr", 32'(o1_prg_addr), mon_e.prg1);
            chk("u1_chr_addr", 32'(o1_chr_addr), mon_e.chr1);
            chk("u1_ciram_a10", 32'(o1_ciram_a10), mon_e.cir1);
            chk("u1_sst_di", 32'(o1_sst_di), mon_e.sst1);
            chk("u1_irq", 32'(o1_irq), mon_e.irq1);
            chk("u1_strobes", 32'({o1_prg_ce, o1_prg_oe, o1_chr_ce, o1_chr_oe, o1_chr_we, o1_ciram_ce}), mon_e.strb);
        end
    end

    // One m2 cycle: randomize the PPU side, queue the expectation, step the models on the falling edge.
    task automatic tick();
        ppu_addr    = 14'($urandom);
        ppu_oe_n    = 1'($urandom);
        ppu_we_n    = 1'($urandom);
        cfg_mir_v   = 1'($urandom);
        cfg_chr_ram = 1'($urandom);
        q.push_back(expect_now());
        @(negedge m2);
        s0 = step(s0, 1'b0, 3, 4, 1'b0);
        s1 = step(s1, 1'b1, 5, 4, IRQ_BUILT);
        #1;
    endtask

    task automatic pick_sst_addr();
        case ($urandom_range(0, 3))
            0: sst_addr = 8'd127;
            1: sst_addr = 8'($urandom);
            default: sst_addr = 8'($urandom_range(0, 5));
        endcase
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            cpu_rw = 1'b1;
            cpu_addr = 16'($urandom);
            pick_sst_addr();
            tick();
        end
    endtask

    task automatic cpu_wr(input logic [15:0] a, input logic [7:0] d);
        cpu_addr = a;
        cpu_data = d;
        cpu_rw = 1'b0;
        pick_sst_addr();
        tick();
        cpu_rw = 1'b1;
    endtask

    task automatic sst_wr(input logic [7:0] idx, input logic [7:0] d);
        sst_act = 1'b1;
        sst_we_reg = 1'b1;
        sst_addr = idx;
        sst_dato = d;
        cpu_rw = 1'b1;
        tick();
        sst_act = 1'b0;
        sst_we_reg = 1'b0;
    endtask

    task automatic rand_addr();
        case ($urandom_range(0, 7))
            0: cpu_addr = 16'h4100;
            1: cpu_addr = 16'h4101;
            2: cpu_addr = 16'h4102;
            3: cpu_addr = 16'h4103;
            4: cpu_addr = 16'h4F00 | 16'($urandom_range(0, 3));
            5: cpu_addr = 16'h5100 | 16'($urandom_range(0, 3));
            6: cpu_addr = 16'h4000 | 16'($urandom_range(0, 3));
            default: cpu_addr = 16'($urandom);
        endcase
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        int seen;
        map_rst_n = 1'b0;
        @(negedge m2);
        s0 = zero_st();
        s1 = zero_st();
        #1;
        idle(2);
        map_rst_n = 1'b1;

        // Packed latch decode and the $8000 mapping.
        cpu_wr(16'h4100, 8'hDB);
        cpu_addr = 16'h8000;
        #1;
        chk("tp_prg_addr_8000", 32'(o0_prg_addr), 32'h18000);
        chk("tp_chr_bank", 32'(o0_chr_addr[16:13]), 32'hB);
        cpu_wr(16'h4000, 8'h00);
        idle(1);

        // Split registers with PRG_BITS=5.
        cpu_wr(16'h4100, 8'h1F);
        cpu_wr(16'h4101, 8'h05);
        #1;
        chk("tp_u1_prg_bank", 32'(o1_prg_addr[19:15]), 32'h1F);
        chk("tp_u1_chr_bank", 32'(o1_chr_addr[16:13]), 32'h5);
        ppu_addr = 14'h2800;
        cfg_mir_v = 1'b0;
        #1;
        chk("tp_mirctl1_a", 32'(o1_ciram_a10), 32'h1);
        chk("tp_mirctl0_h", 32'(o0_ciram_a10), 32'h1);
        cfg_mir_v = 1'b1;
        #1;
        chk("tp_mirctl1_b", 32'(o1_ciram_a10), 32'h1);
        chk("tp_mirctl0_v", 32'(o0_ciram_a10), 32'h0);
        idle(1);

        // IRQ: CPU load, then force a short count through save state.
        cpu_wr(16'h4102, 8'h03);
        cpu_wr(16'h4103, 8'h80);
        idle(3);
        sst_wr(8'd3, 8'd3);
        sst_wr(8'd4, 8'd0);
        sst_wr(8'd5, 8'd2);
        seen = 0;
        for (k = 1; k <= 8; k++) begin
            idle(1);
            if (o1_irq) begin seen = k; break; end
        end
`ifdef MAP_LATCH_IRQ_EN
        chk("tp_irq_latency", 32'(seen), 32'd4);
`else
        chk("tp_irq_absent", 32'(seen), 32'd0);
`endif
        idle(2);
        cpu_wr(16'h4102, 8'h00);
        idle(2);

        // Expiry-edge collisions: hi write reloads, lo write disarms.
        sst_wr(8'd3, 8'd0);
        sst_wr(8'd4, 8'd0);
        sst_wr(8'd5, 8'd2);
        cpu_wr(16'h4103, 8'h02);
        idle(3);
        sst_wr(8'd3, 8'd0);
        sst_wr(8'd4, 8'd0);
        sst_wr(8'd5, 8'd2);
        cpu_wr(16'h4102, 8'h07);
        idle(3);

        // Reset mid-count.
        sst_wr(8'd3, 8'd5);
        sst_wr(8'd4, 8'd0);
        sst_wr(8'd5, 8'd2);
        idle(2);
        map_rst_n = 1'b0;
        idle(1);
        map_rst_n = 1'b1;
        idle(10);

        // Save-state round trip and CPU writes blocked while active.
        for (int i = 0; i < 6; i++) sst_wr(8'(i), 8'($urandom));
        sst_act = 1'b1;
        for (int i = 0; i < 6; i++) begin
            sst_addr = 8'(i);
            cpu_rw = 1'b1;
            tick();
        end
        sst_addr = 8'd0;
        cpu_addr = 16'h4100;
        cpu_data = 8'hFF;
        cpu_rw = 1'b0;
        tick();
        sst_addr = 8'd127;
        cpu_rw = 1'b1;
        tick();
        sst_act = 1'b0;

        // Randomized traffic.
        for (int i = 0; i < 1500; i++) begin
            k = $urandom_range(0, 99);
            sst_act = 1'b0;
            sst_we_reg = 1'b0;
            map_rst_n = 1'b1;
            cpu_rw = 1'b1;
            rand_addr();
            cpu_data = 8'($urandom);
            pick_sst_addr();
            if (k < 55) begin
                cpu_rw = ($urandom_range(0, 3) == 0);
            end else if (k < 70) begin
                sst_act = 1'b1;
                sst_we_reg = ($urandom_range(0, 3) != 0);
                sst_addr = ($urandom_range(0, 7) == 0) ? 8'd127 : 8'($urandom_range(0, 5));
                sst_dato = 8'($urandom);
                if (sst_addr == 8'd4 && $urandom_range(0, 1) == 1) sst_dato = 8'd0;
                if (sst_addr == 8'd3) sst_dato = 8'($urandom_range(0, 12));
                if (sst_addr == 8'd5) sst_dato = 8'd2;
                cpu_rw = ($urandom_range(0, 1) == 0);
            end else if (k < 73) begin
                map_rst_n = 1'b0;
            end
            tick();
        end
        sst_act = 1'b0;
        sst_we_reg = 1'b0;
        map_rst_n = 1'b1;
        cpu_rw = 1'b1;

        for (int i = 0; i < 10 && q.size() > 0; i++) @(posedge m2);
        #1;
        chk("scoreboard_drained", 32'(q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
